// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline registers.
// This covers the control-word layout, the control struct and the skid-buffer state names.
package riscv_pipe_pkg;

    localparam int CTRL_W    = 11;
    localparam int BR        = 10;
    localparam int MW        = 9;
    localparam int MR        = 8;
    localparam int M2R       = 7;
    localparam int ASRC      = 6;
    localparam int RW        = 5;
    localparam int ALUOP_LSB = 3;
    localparam int F3_LSB    = 0;

    typedef struct packed {
        logic       branch;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [2:0] func3;
    } id_ex_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register stage with a one-entry skid buffer and a flush.
// in_ready is derived only from registered state, so it never depends on out_ready.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output pipe_state_e      state
);

    pipe_state_e      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != SKID) & rst_n;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Flush clears whole entries, not only control, so a bubble never carries stale state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        state_q <= SKID;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: payload through a skid buffer, control gated to zero on
// bubbles, plus a saturating count of cycles where EX back-pressures a valid instruction.
module id_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int FUNC_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rd1,
    input  logic [XLEN-1:0]    in_rd2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [FUNC_W-1:0]  in_func,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rd1,
    output logic [XLEN-1:0]    out_rd2,
    output logic [XLEN-1:0]    out_imm,
    output logic [FUNC_W-1:0]  out_func,
    output logic [RADDR_W-1:0] out_rd,
    output logic [CNT_W-1:0]   stall_cnt,
    output pipe_state_e        dbg_state
);

    localparam int PAY_W = CTRL_W + 4 * XLEN + FUNC_W + RADDR_W;

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  out_pay;
    logic [CTRL_W-1:0] ctrl_held;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    assign in_pay = {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_func, in_rd};

    pipe_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay),
        .state     (dbg_state)
    );

    assign {ctrl_held, out_pc, out_rd1, out_rd2, out_imm, out_func, out_rd} = out_pay;

    // A bubble must never present memwrite/regwrite, whatever the stored word holds.
    assign out_ctrl = out_valid ? ctrl_held : '0;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a 64-bit/16-bit-counter instance and a 32-bit/4-bit-counter
// instance share stimulus and are compared each cycle against a queue-based model.
module tb_id_ex_pipe_reg;
  import riscv_pipe_pkg::*;

  localparam int XW = 64;
  localparam int XN = 32;
  localparam int CW = 16;
  localparam int CN = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XW-1:0] in_pc, in_rd1, in_rd2, in_imm;
  logic [3:0] in_func;
  logic [4:0] in_rd;

  logic in_ready_w, out_valid_w;
  logic [CTRL_W-1:0] out_ctrl_w;
  logic [XW-1:0] out_pc_w, out_rd1_w, out_rd2_w, out_imm_w;
  logic [3:0] out_func_w;
  logic [4:0] out_rd_w;
  logic [CW-1:0] stall_w;
  pipe_state_e state_w;

  logic in_ready_n, out_valid_n;
  logic [CTRL_W-1:0] out_ctrl_n;
  logic [XN-1:0] out_pc_n, out_rd1_n, out_rd2_n, out_imm_n;
  logic [3:0] out_func_n;
  logic [4:0] out_rd_n;
  logic [CN-1:0] stall_n;
  pipe_state_e state_n;

  id_ex_pipe_reg #(.XLEN(XW), .RADDR_W(5), .FUNC_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_func(in_func), .in_rd(in_rd), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_ctrl(out_ctrl_w), .out_pc(out_pc_w), .out_rd1(out_rd1_w), .out_rd2(out_rd2_w),
    .out_imm(out_imm_w), .out_func(out_func_w), .out_rd(out_rd_w), .stall_cnt(stall_w),
    .dbg_state(state_w)
  );

  id_ex_pipe_reg #(.XLEN(XN), .RADDR_W(5), .FUNC_W(4), .CNT_W(CN)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_ctrl(in_ctrl), .in_pc(in_pc[XN-1:0]), .in_rd1(in_rd1[XN-1:0]),
    .in_rd2(in_rd2[XN-1:0]), .in_imm(in_imm[XN-1:0]), .in_func(in_func), .in_rd(in_rd),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_ctrl(out_ctrl_n),
    .out_pc(out_pc_n), .out_rd1(out_rd1_n), .out_rd2(out_rd2_n), .out_imm(out_imm_n),
    .out_func(out_func_n), .out_rd(out_rd_n), .stall_cnt(stall_n), .dbg_state(state_n)
  );

  // reference model: in-order queue of accepted items (capacity 2) and two counters
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XW-1:0] pc;
    logic [XW-1:0] rd1;
    logic [XW-1:0] rd2;
    logic [XW-1:0] imm;
    logic [3:0] func;
    logic [4:0] rd;
  } item_t;

  item_t exp_q[$];
  int unsigned m_stall_w = 0;
  int unsigned m_stall_n = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [63:0] pc, input logic [CTRL_W-1:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = ctrl;
    in_rd1   = rand64();
    in_rd2   = rand64();
    in_imm   = rand64();
    in_func  = 4'($urandom_range(0, 15));
    in_rd    = 5'($urandom_range(0, 31));
  endtask

  task automatic compare();
    int sz;
    pipe_state_e exp_st;
    sz = exp_q.size();
    exp_st = (sz == 0) ? EMPTY : ((sz == 1) ? FULL : SKID);
    check("in_ready", 64'(in_ready_w), 64'(rst_n && sz < 2));
    check("in_ready_n", 64'(in_ready_n), 64'(rst_n && sz < 2));
    check("out_valid", 64'(out_valid_w), 64'(sz > 0));
    check("out_valid_n", 64'(out_valid_n), 64'(sz > 0));
    check("state", 64'(state_w), 64'(exp_st));
    check("stall_cnt", 64'(stall_w), 64'(m_stall_w));
    check("stall_cnt_n", 64'(stall_n), 64'(m_stall_n));
    if (sz > 0) begin
      check("out_ctrl", 64'(out_ctrl_w), 64'(exp_q[0].ctrl));
      check("out_ctrl_n", 64'(out_ctrl_n), 64'(exp_q[0].ctrl));
      check("out_pc", out_pc_w, exp_q[0].pc);
      check("out_rd1", out_rd1_w, exp_q[0].rd1);
      check("out_rd2", out_rd2_w, exp_q[0].rd2);
      check("out_imm", out_imm_w, exp_q[0].imm);
      check("out_func", 64'(out_func_w), 64'(exp_q[0].func));
      check("out_rd", 64'(out_rd_w), 64'(exp_q[0].rd));
      check("out_pc_n", 64'(out_pc_n), 64'(exp_q[0].pc[XN-1:0]));
      check("out_rd1_n", 64'(out_rd1_n), 64'(exp_q[0].rd1[XN-1:0]));
      check("out_imm_n", 64'(out_imm_n), 64'(exp_q[0].imm[XN-1:0]));
    end else begin
      check("bubble_ctrl", 64'(out_ctrl_w), 64'd0);
      check("bubble_ctrl_n", 64'(out_ctrl_n), 64'd0);
    end
  endtask

  // one clock: model the edge from the inputs as driven, then check at the falling edge
  task automatic step();
    item_t cur;
    logic in_fire, out_fire, stalled;
    cur      = {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_func, in_rd};
    in_fire  = in_valid && rst_n && exp_q.size() < 2;
    out_fire = exp_q.size() > 0 && out_ready;
    stalled  = exp_q.size() > 0 && !out_ready;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_stall_w = 0;
      m_stall_n = 0;
    end else begin
      if (stalled && m_stall_w < (2**CW - 1)) m_stall_w++;
      if (stalled && m_stall_n < (2**CN - 1)) m_stall_n++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) exp_q.push_back(cur);
      end
    end
    @(negedge clk);
    compare();
  endtask

  logic [CTRL_W-1:0] side_fx;

  initial begin
    side_fx = '0;
    side_fx[RW] = 1'b1;
    side_fx[MW] = 1'b1;

    // reset with a valid instruction pending
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 64'h1000, 11'h7FF);
    @(negedge clk);
    step();
    step();
    check("rst_out_pc", out_pc_w, 64'd0);
    check("rst_out_pc_n", 64'(out_pc_n), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 64'h0, '0);
    step();

    // back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(i * 4), 11'($urandom_range(0, 2047)));
      step();
    end
    drive(1'b0, 64'h0, '0);
    step();
    step();

    // back-pressure: 0x40 held, 0x44 parked in the skid entry
    out_ready = 1'b0;
    drive(1'b1, 64'h40, 11'h021);
    step();
    drive(1'b1, 64'h44, 11'h022);
    step();
    drive(1'b0, 64'h0, '0);
    step();
    step();
    check("bp_stall3", 64'(stall_w), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // flush while SKID with a simultaneous side-effecting input
    out_ready = 1'b0;
    drive(1'b1, 64'h50, 11'h001);
    step();
    drive(1'b1, 64'h54, 11'h002);
    step();
    drive(1'b1, 64'h80, side_fx);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'h0, '0);
    for (int i = 0; i < 3; i++) step();

    // stall counter saturation
    out_ready = 1'b0;
    drive(1'b1, 64'h60, 11'h003);
    step();
    drive(1'b0, 64'h0, '0);
    for (int i = 0; i < 20; i++) step();
    check("sat_n", 64'(stall_n), 64'hF);
    out_ready = 1'b1;
    step();

    // narrow-width boundary values
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 11'h010);
    in_imm = 64'h0000_0000_8000_0000;
    step();
    drive(1'b0, 64'h0, '0);
    step();

    // reset and flush together while SKID
    out_ready = 1'b0;
    drive(1'b1, 64'h90, 11'h004);
    step();
    drive(1'b1, 64'h94, 11'h005);
    step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    rst_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'h0, '0);
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 3) != 0), rand64(), 11'($urandom_range(0, 2047)));
      step();
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID→EX pipeline register; successor to the fixed-width ID/EX latch.
- Adds a valid/ready handshake with a 1-entry skid buffer (full throughput under back-pressure), flush/bubble insertion, a full-width PC, synchronous active-low reset and a saturating stall counter.
- Sits between decode/register-read and the ALU/EX stage of the 5-stage RISC-V core.

Parameters:
- XLEN, 64, width of PC, RD1, RD2, Immgen.
- RADDR_W, 5, destination register index width.
- FUNC_W, 4, ALU function field width ({funct7[5], funct3}).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  kill all held entries; next output is a bubble.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  register can accept this cycle.
- in_ctrl  in  CTRL_W  packed control {branch, memwrite, memread, memtoreg, alusrc, regwrite, ALUop[1:0], func3[2:0]}.
- in_pc  in  XLEN  instruction PC.
- in_rd1, in_rd2  in  XLEN  register-file read data.
- in_imm  in  XLEN  immediate.
- in_func  in  FUNC_W  ALU function field.
- in_rd  in  RADDR_W  destination register.
- out_valid  out  1  EX holds a valid instruction.
- out_ready  in  1  EX consumes this cycle.
- out_ctrl, out_pc, out_rd1, out_rd2, out_imm, out_func, out_rd  out  (as inputs)  registered payload.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- All state updates on posedge clk. Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry, each holding payload plus a valid bit.
- State encoding: EMPTY (main empty), FULL (main only), SKID (main + skid). in_ready = (state != SKID) & rst_n, taken from registered state only, with no combinational path from out_ready.
- EMPTY: input fire → FULL, main ← in.
- FULL:
  - input fire and output fire → FULL, main ← in.
  - input fire only → SKID, skid ← in.
  - output fire only → EMPTY.
  - otherwise hold.
- SKID: output fire → FULL, main ← skid. Otherwise hold. No input fire is possible.
- Latency: 1 cycle from input fire to out_valid when EMPTY. Throughput: 1 instruction/cycle under continuous out_ready=1.
- Ordering: strict FIFO; a skid entry never overtakes the main entry.
- flush has priority over everything: next state EMPTY, both valid bits cleared, stored ctrl fields zeroed. Any input fire in the same cycle is discarded. Payload data fields may keep stale values.
- Bubble guarantee: out_ctrl = 0 whenever out_valid = 0 (gated combinationally), so memwrite and regwrite can never assert on a bubble.
- stall_cnt: increments when out_valid & ~out_ready, saturates at all-ones, is not cleared by flush.
- Reset (rst_n = 0 at posedge):
  - state EMPTY, all payload registers 0, out_valid 0, stall_cnt 0.
  - in_ready is held 0 while rst_n = 0.
  - Reset mid-transfer drops both entries.
- Simultaneous flush and rst_n = 0: reset wins; the result is identical.

Decomposition:
- Shared package `riscv_pipe_pkg`:
  - CTRL_W = 11.
  - Control bit-position localparams (BR, MW, MR, M2R, ASRC, RW, ALUOP_LSB, F3_LSB).
  - Packed struct id_ex_ctrl_t.
  - State enum {EMPTY, FULL, SKID}.
- One natural sub-module: `pipe_skid_buf`, a generic WIDTH-parametrised valid/ready skid register with flush.
  - id_ex_pipe_reg packs the payload ({ctrl, pc, rd1, rd2, imm, func, rd}) into one vector, instantiates it, unpacks the result, and adds the ctrl gating and stall counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_pc=0x1000 → out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=0. After release, in_ready=1.
- Streaming: 8 back-to-back inputs, PC 0x0..0x1C step 4, out_ready=1 → outputs appear 1 cycle later in order, one per cycle, in_ready constantly 1, stall_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles while sending PC 0x40, 0x44:
  - 0x40 is held on the outputs, 0x44 goes to skid, in_ready=0 from the next cycle.
  - stall_cnt=3.
  - On release, 0x40 then 0x44 are output, no loss or duplication.
- Flush in SKID with a simultaneous input PC 0x80 (regwrite=1, memwrite=1) → next cycle out_valid=0, out_ctrl=0, in_ready=1. PC 0x80 never appears at the output.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 → stall_cnt stops at 0xF.
- Width generalisation: XLEN=32, in_pc=0xFFFF_FFFC, in_imm=0x8000_0000 → identical values on out_pc and out_imm after 1 cycle.
